// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants for the writeback stage and register file.
// Optional feature macro: WB_BYPASS_EN (write-through reads in the register file).
package wb_stage_pkg;
  localparam int XLEN       = 64;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [XLEN-1:0] ZERO_WORD = '0;

  // MemtoReg encodings
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef logic [XLEN-1:0]       reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 is hardwired to zero; any write aimed at it is dropped
  function automatic logic is_real_reg(input reg_addr_t a);
    return a != '0;
  endfunction
endpackage

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile: NREGS x XLEN integer register file, one write port,
// two combinational read ports, x0 reads as zero.
// WB_BYPASS_EN: a read of the register being written this cycle returns
// the write data instead of the stored value.
module wb_stage_regfile
  import wb_stage_pkg::*;
#(
  parameter int W  = XLEN,
  parameter int NR = NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [W-1:0]          i_wdata,
  input  logic [REG_ADDR_W-1:0] i_r1_addr,
  output logic [W-1:0]          o_r1_data,
  input  logic [REG_ADDR_W-1:0] i_r2_addr,
  output logic [W-1:0]          o_r2_data
);

  logic [W-1:0] r_regs [NR];

  // Array write; x0 is never written so it stays zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) r_regs[i] <= '0;
    end else if (i_we && is_real_reg(i_waddr)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port 1: zero for x0, optional write-through of the committing value
  always_comb begin
    o_r1_data = r_regs[i_r1_addr];
    if (!is_real_reg(i_r1_addr)) o_r1_data = '0;
`ifdef WB_BYPASS_EN
    else if (i_we && (i_r1_addr == i_waddr)) o_r1_data = i_wdata;
`else
`endif
  end

  // Read port 2: same rules as port 1
  always_comb begin
    o_r2_data = r_regs[i_r2_addr];
    if (!is_real_reg(i_r2_addr)) o_r2_data = '0;
`ifdef WB_BYPASS_EN
    else if (i_we && (i_r2_addr == i_waddr)) o_r2_data = i_wdata;
`else
`endif
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, writeback mux, register-file commit
// and retired-instruction counter.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-through reads,
// implemented inside wb_stage_regfile).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = wb_stage_pkg::XLEN,
  parameter int NREGS = wb_stage_pkg::NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic [XLEN-1:0]       m_data,
  input  logic                  m_w_ena,
  input  logic [REG_ADDR_W-1:0] m_w_addr,
  input  logic                  wb_signal,
  input  logic                  reg_wr,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] r1_addr,
  output logic [XLEN-1:0]       r1_data,
  input  logic [REG_ADDR_W-1:0] r2_addr,
  output logic [XLEN-1:0]       r2_data,
  output logic                  wb_w_ena,
  output logic [REG_ADDR_W-1:0] wb_w_addr,
  output logic [XLEN-1:0]       wb_w_data,
  output logic [63:0]           retire_cnt
);

  // MEM/WB pipeline register fields
  logic                  r_valid;
  logic [XLEN-1:0]       r_data;
  logic [XLEN-1:0]       r_rdata;
  logic                  r_w_ena;
  logic [REG_ADDR_W-1:0] r_w_addr;
  logic                  r_wb_sel;
  logic                  r_reg_wr;
  logic [63:0]           r_retire_cnt;

  logic                  w_commit;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [XLEN-1:0]       w_data;

  // MEM/WB capture with priority reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_rdata  <= '0;
      r_w_ena  <= 1'b0;
      r_w_addr <= '0;
      r_wb_sel <= WB_SEL_ALU;
      r_reg_wr <= 1'b0;
    end else if (!stall) begin
      r_valid  <= m_valid;
      r_data   <= m_data;
      r_rdata  <= mem_rdata;
      r_w_ena  <= m_w_ena;
      r_w_addr <= m_w_addr;
      r_wb_sel <= wb_signal;
      r_reg_wr <= reg_wr;
    end
  end

  // An instruction retires on the edge it leaves WB; a stalled one is held
  // and counted only once. Flush does not gate the count.
  always_ff @(posedge clk) begin
    if (rst) r_retire_cnt <= '0;
    else if (r_valid && !stall) r_retire_cnt <= r_retire_cnt + 64'd1;
  end

  // Writeback select and commit qualification; address is zeroed when idle
  always_comb begin
    w_commit = r_valid & r_reg_wr & r_w_ena & is_real_reg(r_w_addr);
    w_data   = (r_wb_sel == WB_SEL_MEM) ? r_rdata : r_data;
    w_addr   = w_commit ? r_w_addr : '0;
  end

  // Commit proceeds regardless of stall; a held write simply repeats
  wb_stage_regfile #(
    .W  (XLEN),
    .NR (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_commit),
    .i_waddr   (w_addr),
    .i_wdata   (w_data),
    .i_r1_addr (r1_addr),
    .o_r1_data (r1_data),
    .i_r2_addr (r2_addr),
    .o_r2_data (r2_data)
  );

  assign wb_w_ena   = w_commit;
  assign wb_w_addr  = w_addr;
  assign wb_w_data  = w_data;
  assign retire_cnt = r_retire_cnt;

endmodule
